// File: rtl/br_pkg.sv
// br_pkg: shared types for the branch resolve unit.
// Branch-type encoding, predictor-update entry, width helper.
package br_pkg;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BEQ     = 4'd1,
    BNE     = 4'd2,
    BLT     = 4'd3,
    BGE     = 4'd4,
    BLTU    = 4'd5,
    BGEU    = 4'd6,
    B       = 4'd7,
    BL      = 4'd8,
    JIRL    = 4'd9
  } br_type_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } upd_entry_t;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/br_resolve_if.sv
// br_resolve_if: execute-lane inputs, redirect outputs and the
// predictor-update valid/ready stream of br_resolve.
interface br_resolve_if
  import br_pkg::*;
#(
  parameter int NLANE = 2
);
  localparam int LW = idx_w(NLANE);

  logic                   stall;
  logic [NLANE-1:0]       ex_valid;
  logic [NLANE-1:0][31:0] ex_pc;
  logic [NLANE-1:0][31:0] ex_rdata1;
  logic [NLANE-1:0][31:0] ex_rdata2;
  logic [NLANE-1:0][31:0] ex_imm;
  logic [NLANE-1:0][31:0] ex_pd_target;
  logic [NLANE-1:0][3:0]  ex_br_type;
  logic [NLANE-1:0]       ex_pd_taken;

  logic                   redirect;
  logic [31:0]            redirect_pc;
  logic [LW-1:0]          redirect_lane;
  logic [NLANE-1:0]       kill_mask;

  logic                   upd_valid;
  logic                   upd_ready;
  logic [31:0]            upd_pc;
  logic [31:0]            upd_target;
  logic                   upd_taken;
  logic [15:0]            upd_drop_cnt;

  modport master (
    output stall, ex_valid, ex_pc, ex_rdata1, ex_rdata2,
    output ex_imm, ex_pd_target, ex_br_type, ex_pd_taken,
    output upd_ready,
    input  redirect, redirect_pc, redirect_lane, kill_mask,
    input  upd_valid, upd_pc, upd_target, upd_taken,
    input  upd_drop_cnt
  );

  modport slave (
    input  stall, ex_valid, ex_pc, ex_rdata1, ex_rdata2,
    input  ex_imm, ex_pd_target, ex_br_type, ex_pd_taken,
    input  upd_ready,
    output redirect, redirect_pc, redirect_lane, kill_mask,
    output upd_valid, upd_pc, upd_target, upd_taken,
    output upd_drop_cnt
  );

endinterface

// File: rtl/br_eval.sv
// br_eval: per-lane branch direction, target and mispredict.
// Macro BR_TARGET_CHECK_EN adds taken-target mismatch detection.
module br_eval
  import br_pkg::*;
(
  input  logic        valid,
  input  logic [3:0]  br_type,
  input  logic [31:0] pc,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic [31:0] imm,
  input  logic [31:0] pd_target,
  input  logic        pd_taken,
  output logic        is_br,
  output logic        taken,
  output logic [31:0] target,
  output logic        mispred,
  output logic [31:0] correct_pc
);

`ifdef BR_TARGET_CHECK_EN
  localparam bit TGT_CHK = 1'b1;
`else
  localparam bit TGT_CHK = 1'b0;
`endif

  br_type_e bt;
  logic     dir_mis;
  logic     tgt_mis;

  assign bt    = br_type_e'(br_type);
  assign is_br = valid && (bt != BR_NONE);

  always_comb begin
    unique case (bt)
      BEQ:         taken = rdata1 == rdata2;
      BNE:         taken = rdata1 != rdata2;
      BLT:         taken = $signed(rdata1) < $signed(rdata2);
      BGE:         taken = $signed(rdata1) >= $signed(rdata2);
      BLTU:        taken = rdata1 < rdata2;
      BGEU:        taken = rdata1 >= rdata2;
      B, BL, JIRL: taken = 1'b1;
      default:     taken = 1'b0;
    endcase
  end

  assign target = (bt == JIRL) ? rdata1 + imm : pc + imm;

  assign dir_mis = pd_taken != taken;
  assign tgt_mis = TGT_CHK && pd_taken && taken
                && (pd_target != target);

  assign mispred    = is_br && (dir_mis || tgt_mis);
  assign correct_pc = taken ? target : pc + 32'd4;

endmodule

// File: rtl/br_resolve.sv
// br_resolve: multi-lane branch resolve, redirect and update FIFO.
// Optional macro BR_TARGET_CHECK_EN (see br_eval).
module br_resolve
  import br_pkg::*;
#(
  parameter int NLANE      = 2,
  parameter int UPD_DEPTH  = 4,
  parameter int SHADOW_CYC = 1
) (
  input logic         clk,
  input logic         rstn,
  br_resolve_if.slave bus
);

  localparam int LW = idx_w(NLANE);
  localparam int AW = idx_w(UPD_DEPTH);
  localparam int CW = $clog2(UPD_DEPTH + 1);
  localparam int PW = $clog2(NLANE + 1);
  localparam int SW = $clog2(SHADOW_CYC + 1);

  typedef enum logic {IDLE, SHADOW} state_e;

  logic [NLANE-1:0]       is_br;
  logic [NLANE-1:0]       taken;
  logic [NLANE-1:0]       mispred;
  logic [NLANE-1:0][31:0] target;
  logic [NLANE-1:0][31:0] cpc;

  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    br_eval u_eval (
      .valid      (bus.ex_valid[i]),
      .br_type    (bus.ex_br_type[i]),
      .pc         (bus.ex_pc[i]),
      .rdata1     (bus.ex_rdata1[i]),
      .rdata2     (bus.ex_rdata2[i]),
      .imm        (bus.ex_imm[i]),
      .pd_target  (bus.ex_pd_target[i]),
      .pd_taken   (bus.ex_pd_taken[i]),
      .is_br      (is_br[i]),
      .taken      (taken[i]),
      .target     (target[i]),
      .mispred    (mispred[i]),
      .correct_pc (cpc[i])
    );
  end

  state_e        state, state_n;
  logic [SW-1:0] cnt, cnt_n;
  logic          active;

  logic             win;
  logic [LW-1:0]    win_lane;
  logic [31:0]      win_pc;
  logic [NLANE-1:0] kill;
  logic [NLANE-1:0] push;
  logic [PW-1:0]    npush;

  always_ff @(posedge clk) begin
    if (rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (!bus.stall) begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (win) begin
          state_n = SHADOW;
          cnt_n   = SW'(SHADOW_CYC);
        end
      end
      SHADOW: begin
        cnt_n = cnt - SW'(1);
        if (cnt <= SW'(1))
          state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    active = (state == IDLE) && !bus.stall;
  end

  // Scan oldest-first: lanes past the first mispredict are killed.
  always_comb begin
    win      = 1'b0;
    win_lane = '0;
    win_pc   = '0;
    kill     = '0;
    push     = '0;
    npush    = '0;
    for (int i = 0; i < NLANE; i++) begin
      kill[i] = win;
      push[i] = active && is_br[i] && !win;
      npush   = npush + PW'(push[i]);
      if (active && mispred[i] && !win) begin
        win      = 1'b1;
        win_lane = LW'(i);
        win_pc   = cpc[i];
      end
    end
  end

  logic             red_q;
  logic [31:0]      red_pc_q;
  logic [LW-1:0]    red_lane_q;
  logic [NLANE-1:0] kill_q;

  always_ff @(posedge clk) begin
    if (rstn) begin
      red_q      <= 1'b0;
      red_pc_q   <= '0;
      red_lane_q <= '0;
      kill_q     <= '0;
    end else if (!bus.stall) begin
      red_q      <= win;
      red_pc_q   <= win_pc;
      red_lane_q <= win_lane;
      kill_q     <= kill;
    end
  end

  assign bus.redirect      = red_q && !bus.stall;
  assign bus.redirect_pc   = red_pc_q;
  assign bus.redirect_lane = red_lane_q;
  assign bus.kill_mask     = kill_q;

  upd_entry_t             mem [UPD_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic [15:0]            drop;
  logic [16:0]            dsum;
  logic [15:0]            drop_sat;
  logic                   pop;
  logic                   fits;
  logic                   do_push;
  logic [NLANE-1:0][AW-1:0] slot;
  logic [AW-1:0]          off;

  assign pop  = bus.upd_valid && bus.upd_ready;
  // A pop in the same cycle does not free a slot for this cycle's pushes.
  assign fits = 32'(npush) <= 32'(UPD_DEPTH) - 32'(count);
  assign do_push = (npush != '0) && fits;

  assign dsum     = {1'b0, drop} + 17'(npush);
  assign drop_sat = dsum[16] ? 16'hFFFF : dsum[15:0];

  always_comb begin
    slot = '0;
    off  = '0;
    for (int i = 0; i < NLANE; i++) begin
      slot[i] = wr_ptr + off;
      if (push[i])
        off = off + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NLANE; i++) begin
      if (do_push && push[i])
        mem[slot[i]] <= '{pc:     bus.ex_pc[i],
                          taken:  taken[i],
                          target: target[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop   <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(npush);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + (do_push ? CW'(npush) : '0) - CW'(pop);
      if ((npush != '0) && !fits)
        drop <= drop_sat;
    end
  end

  assign bus.upd_valid    = count != '0;
  assign bus.upd_pc       = bus.upd_valid ? mem[rd_ptr].pc : '0;
  assign bus.upd_taken    = bus.upd_valid && mem[rd_ptr].taken;
  assign bus.upd_target   = bus.upd_valid ? mem[rd_ptr].target : '0;
  assign bus.upd_drop_cnt = drop;

endmodule

// File: tb/tb_br_resolve.sv
// tb_br_resolve: directed and random stimulus for br_resolve,
// scored against a queue-based behavioural model.
module tb_br_resolve;
  import br_pkg::*;

  localparam int NLANE = 2;
  localparam int DEPTH = 4;
  localparam int SHC   = 1;
`ifdef BR_TARGET_CHECK_EN
  localparam bit TGT = 1'b1;
`else
  localparam bit TGT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  br_resolve_if #(.NLANE(NLANE)) bus ();

  br_resolve #(
    .NLANE(NLANE), .UPD_DEPTH(DEPTH), .SHADOW_CYC(SHC)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  typedef struct {
    logic [31:0] pc;
    bit          taken;
    logic [31:0] target;
  } ent_t;

  ent_t             q[$];
  int               shadow_left;
  int               drop;
  bit               m_red;
  logic [31:0]      m_pc;
  int               m_lane;
  logic [NLANE-1:0] m_kill;
  int               n_cmp = 0;
  int               n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic bit ref_taken(int t, logic [31:0] a, logic [31:0] b);
    int sa = a;
    int sb = b;
    case (t)
      1: return a == b;
      2: return a != b;
      3: return sa < sb;
      4: return sa >= sb;
      5: return a < b;
      6: return a >= b;
      7, 8, 9: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    bit          do_pop;
    int          win;
    int          t;
    bit          tk, mis, pd;
    logic [31:0] tg, pc;
    ent_t        pend[$];
    if (rstn) begin
      q.delete();
      shadow_left = 0;
      drop = 0;
      m_red = 0;
      return;
    end
    do_pop = (q.size() > 0) && bus.upd_ready;
    if (!bus.stall) begin
      win = -1;
      if (shadow_left > 0) begin
        shadow_left--;
      end else begin
        for (int i = 0; i < NLANE; i++) begin
          t = int'(bus.ex_br_type[i]);
          if (win < 0 && bus.ex_valid[i] && t != 0) begin
            pc = bus.ex_pc[i];
            pd = bus.ex_pd_taken[i];
            tk = ref_taken(t, bus.ex_rdata1[i], bus.ex_rdata2[i]);
            tg = (t == 9) ? bus.ex_rdata1[i] + bus.ex_imm[i]
                          : pc + bus.ex_imm[i];
            mis = (tk != pd) ||
                  (TGT && pd && tk && bus.ex_pd_target[i] != tg);
            pend.push_back('{pc, tk, tg});
            if (mis) begin
              win = i;
              m_pc = tk ? tg : pc + 32'd4;
            end
          end
        end
        if (pend.size() > DEPTH - q.size()) begin
          drop = drop + pend.size();
          if (drop > 65535) drop = 65535;
        end else begin
          foreach (pend[k]) q.push_back(pend[k]);
        end
        if (win >= 0) shadow_left = SHC;
      end
      m_red = (win >= 0);
      if (m_red) begin
        m_lane = win;
        for (int j = 0; j < NLANE; j++) m_kill[j] = (j > win);
      end
    end
    if (do_pop) void'(q.pop_front());
  endtask

  task automatic cyc();
    bit exp_red;
    @(negedge clk);
    exp_red = m_red && !bus.stall;
    chk("redirect", 32'(bus.redirect), 32'(exp_red));
    if (exp_red) begin
      chk("redirect_pc", bus.redirect_pc, m_pc);
      chk("redirect_lane", 32'(bus.redirect_lane), m_lane);
      chk("kill_mask", 32'(bus.kill_mask), 32'(m_kill));
    end
    chk("upd_valid", 32'(bus.upd_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("upd_pc", bus.upd_pc, q[0].pc);
      chk("upd_taken", 32'(bus.upd_taken), 32'(q[0].taken));
      chk("upd_target", bus.upd_target, q[0].target);
    end
    chk("upd_drop_cnt", 32'(bus.upd_drop_cnt), drop);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.stall        = 1'b0;
    bus.upd_ready    = 1'b0;
    bus.ex_valid     = '0;
    bus.ex_br_type   = '0;
    bus.ex_pc        = '0;
    bus.ex_rdata1    = '0;
    bus.ex_rdata2    = '0;
    bus.ex_imm       = '0;
    bus.ex_pd_target = '0;
    bus.ex_pd_taken  = '0;
  endtask

  task automatic set_lane(int i, logic [3:0] t, logic [31:0] pc,
                          logic [31:0] r1, logic [31:0] r2,
                          logic [31:0] imm, bit pd, logic [31:0] pdt);
    bus.ex_valid[i]     = 1'b1;
    bus.ex_br_type[i]   = t;
    bus.ex_pc[i]        = pc;
    bus.ex_rdata1[i]    = r1;
    bus.ex_rdata2[i]    = r2;
    bus.ex_imm[i]       = imm;
    bus.ex_pd_taken[i]  = pd;
    bus.ex_pd_target[i] = pdt;
  endtask

  task automatic do_reset();
    clr_in();
    rstn = 1'b1;
    cyc();
    rstn = 1'b0;
  endtask

  task automatic rand_in();
    int          t;
    logic [31:0] r1, r2, pc, imm, raw;
    rstn          = ($urandom_range(0, 99) < 2);
    bus.stall     = ($urandom_range(0, 99) < 15);
    bus.upd_ready = 1'($urandom_range(0, 1));
    for (int i = 0; i < NLANE; i++) begin
      t = $urandom_range(0, 12);
      if (t > 9) t = 0;
      r1  = $urandom;
      r2  = ($urandom_range(0, 2) == 0) ? r1 : $urandom;
      pc  = $urandom & 32'hFFFF_FFFC;
      raw = $urandom;
      imm = {{20{raw[11]}}, raw[11:2], 2'b00};
      bus.ex_valid[i]     = ($urandom_range(0, 3) != 0);
      bus.ex_br_type[i]   = 4'(t);
      bus.ex_pc[i]        = pc;
      bus.ex_rdata1[i]    = r1;
      bus.ex_rdata2[i]    = r2;
      bus.ex_imm[i]       = imm;
      bus.ex_pd_taken[i]  = 1'($urandom_range(0, 1));
      bus.ex_pd_target[i] = ($urandom_range(0, 1) != 0) ? pc + imm : $urandom;
    end
  endtask

  initial begin
    int n;
    clr_in();
    rstn = 1'b1;
    model_step();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    chk("rst_redirect", 32'(bus.redirect), 0);
    chk("rst_redirect_pc", bus.redirect_pc, 0);
    chk("rst_lane", 32'(bus.redirect_lane), 0);
    chk("rst_kill", 32'(bus.kill_mask), 0);
    chk("rst_upd_valid", 32'(bus.upd_valid), 0);
    chk("rst_upd_pc", bus.upd_pc, 0);
    chk("rst_upd_target", bus.upd_target, 0);
    chk("rst_drop", 32'(bus.upd_drop_cnt), 0);

    // oldest lane BEQ taken but predicted not-taken
    do_reset();
    set_lane(0, BEQ, 32'h1000, 5, 5, 32'h40, 1'b0, 0);
    cyc();
    clr_in();
    #1;
    chk("d1_redirect", 32'(bus.redirect), 1);
    chk("d1_pc", bus.redirect_pc, 32'h1040);
    chk("d1_lane", 32'(bus.redirect_lane), 0);
    chk("d1_kill", 32'(bus.kill_mask), 32'h2);
    cyc();

    // two mispredicts, lane 0 wins and only it pushes
    do_reset();
    set_lane(0, BNE, 32'h2000, 7, 7, 32'h10, 1'b1, 0);
    set_lane(1, JIRL, 32'h2004, 32'h2000, 0, 32'h8, 1'b0, 0);
    cyc();
    clr_in();
    bus.upd_ready = 1'b1;
    #1;
    chk("d2_pc", bus.redirect_pc, 32'h2004);
    chk("d2_kill", 32'(bus.kill_mask), 32'h2);
    chk("d2_upd_valid", 32'(bus.upd_valid), 1);
    chk("d2_upd_pc", bus.upd_pc, 32'h2000);
    cyc();
    chk("d2_single_push", 32'(bus.upd_valid), 0);

    // back-to-back mispredicts: second falls in the shadow
    do_reset();
    set_lane(0, B, 32'h100, 0, 0, 32'h20, 1'b0, 0);
    cyc();
    chk("d3_first", 32'(bus.redirect), 1);
    cyc();
    chk("d3_shadow", 32'(bus.redirect), 0);
    cyc();
    chk("d3_third", 32'(bus.redirect), 1);
    chk("d3_third_pc", bus.redirect_pc, 32'h120);
    clr_in();
    cyc();

    // FIFO overflow drops the whole cycle's pushes
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_lane(0, BEQ, 32'h400 + 32'(8 * c), 1, 2, 32'h10, 1'b0, 0);
      set_lane(1, BEQ, 32'h404 + 32'(8 * c), 1, 2, 32'h10, 1'b0, 0);
      cyc();
    end
    chk("d4_drop", 32'(bus.upd_drop_cnt), 2);
    clr_in();
    bus.upd_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.upd_valid) n++;
      cyc();
    end
    chk("d4_count", n, 4);

    // stall right after a mispredict defers the redirect
    do_reset();
    set_lane(0, BLT, 32'h500, 32'hFFFF_FFFF, 1, 32'h30, 1'b0, 0);
    cyc();
    clr_in();
    bus.stall = 1'b1;
    #1;
    chk("d5_stalled", 32'(bus.redirect), 0);
    cyc();
    bus.stall = 1'b0;
    #1;
    chk("d5_unstalled", 32'(bus.redirect), 1);
    chk("d5_pc", bus.redirect_pc, 32'h530);
    cyc();
    set_lane(0, B, 32'h600, 0, 0, 32'h40, 1'b0, 0);
    cyc();
    clr_in();
    rstn = 1'b1;
    cyc();
    rstn = 1'b0;
    set_lane(0, B, 32'h700, 0, 0, 32'h40, 1'b0, 0);
    cyc();
    clr_in();
    #1;
    chk("d5_post_rst", 32'(bus.redirect), 1);
    chk("d5_post_rst_pc", bus.redirect_pc, 32'h740);
    cyc();

    // JIRL with correct direction but wrong predicted target
    do_reset();
    set_lane(0, JIRL, 32'h50, 32'h3000, 0, 32'h4, 1'b1, 32'h3000);
    cyc();
    clr_in();
    #1;
    chk("d6_redirect", 32'(bus.redirect), 32'(TGT));
`ifdef BR_TARGET_CHECK_EN
    chk("d6_pc", bus.redirect_pc, 32'h3004);
`endif
    cyc();

    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rand_in();
      cyc();
    end
    clr_in();
    rstn = 1'b0;
    bus.upd_ready = 1'b1;
    for (int k = 0; k < 8; k++) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
